// File: rtl/mem_seq_pkg.sv
// Shared types, mode constants and the test-pattern function for the memory sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned MODE_WR    = 0;
  localparam int unsigned MODE_WR_RD = 1;
  localparam int unsigned MODE_RD    = 2;

  localparam int unsigned WORD_W = 64;

  // Word stored at an address: seed XOR address; callers truncate to their data width.
  function automatic logic [WORD_W-1:0] pattern_word(input logic [WORD_W-1:0] pattern,
                                                     input logic [WORD_W-1:0] addr);
    return pattern ^ addr;
  endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// Beat index counter and request address generator for the memory sequencer.
module mem_seq_addr_gen
  import mem_seq_pkg::*;
#(
  parameter int unsigned             ADDR_W      = 32,
  parameter int unsigned             NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0]       BASE_ADDR   = '0,
  parameter int unsigned             ADDR_STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic [ADDR_W-1:0] addr_n;

  // Address advances by the stride with natural wrap at 2^ADDR_W.
  always_comb begin
    idx_n  = idx;
    addr_n = addr;
    if (clr) begin
      idx_n  = '0;
      addr_n = BASE_ADDR;
    end else if (inc) begin
      idx_n  = idx + IDX_W'(1);
      addr_n = addr + ADDR_W'(ADDR_STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      addr <= '0;
    end else begin
      idx  <= idx_n;
      addr <= addr_n;
    end
  end

  assign last_c = (idx == IDX_W'(NUM_WORDS - 1));

endmodule

// File: rtl/mem_seq_master.sv
// Programmable write / read-back burst generator on a valid/ready memory port,
// reporting pass/fail, mismatch count, first failing address and handshake timeout.
module mem_seq_master
  import mem_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       ADDR_STRIDE = 4,
  parameter logic [31:0]       PATTERN     = 32'hABCD1234,
  parameter int unsigned       MODE        = 1,
  parameter int unsigned       TIMEOUT     = 255,
  localparam int unsigned      ERR_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic              valid_n, write_n, busy_n, done_n, pass_n, timeout_n;
  logic [DATA_W-1:0] wdata_n;
  logic [ERR_W-1:0]  err_n;
  logic [ADDR_W-1:0] ferr_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              clr, inc, go_done, last_c;
  logic              accept_c, stall_c, abort_c;

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return DATA_W'(pattern_word(WORD_W'(PATTERN), WORD_W'(a)));
  endfunction

  mem_seq_addr_gen #(
    .ADDR_W      (ADDR_W),
    .NUM_WORDS   (NUM_WORDS),
    .BASE_ADDR   (BASE_ADDR),
    .ADDR_STRIDE (ADDR_STRIDE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (inc),
    .addr   (mem_addr),
    .last_c (last_c)
  );

  assign accept_c = mem_valid && mem_ready;
  assign stall_c  = mem_valid && !mem_ready;
  // Acceptance always beats the timeout because a stall requires !mem_ready.
  assign abort_c  = stall_c && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_n   = state;
    valid_n   = mem_valid;
    write_n   = mem_write;
    wdata_n   = mem_wdata;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    timeout_n = timeout;
    err_n     = err_count;
    ferr_n    = first_err_addr;
    wait_n    = wait_cnt;
    clr       = 1'b0;
    inc       = 1'b0;
    go_done   = 1'b0;
    if (stall_c) wait_n = wait_cnt + WAIT_W'(1);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr       = 1'b1;
          busy_n    = 1'b1;
          valid_n   = 1'b1;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          timeout_n = 1'b0;
          err_n     = '0;
          ferr_n    = '0;
          wait_n    = '0;
          if (MODE == MODE_RD) begin
            state_n = ST_RD;
            write_n = 1'b0;
            wdata_n = '0;
          end else begin
            state_n = ST_WR;
            write_n = 1'b1;
            wdata_n = word_at(BASE_ADDR);
          end
        end
      end
      ST_WR: begin
        if (accept_c) begin
          wait_n = '0;
          if (!last_c) begin
            inc     = 1'b1;
            wdata_n = word_at(mem_addr + ADDR_W'(ADDR_STRIDE));
          end else if (MODE == MODE_WR_RD) begin
            clr     = 1'b1;
            state_n = ST_RD;
            write_n = 1'b0;
            wdata_n = '0;
          end else begin
            go_done = 1'b1;
          end
        end else if (abort_c) begin
          timeout_n = 1'b1;
          go_done   = 1'b1;
        end
      end
      ST_RD: begin
        if (accept_c) begin
          wait_n = '0;
          if (mem_rdata != word_at(mem_addr)) begin
            if (err_count == '0) ferr_n = mem_addr;
            if (err_count != ERR_W'(NUM_WORDS)) err_n = err_count + ERR_W'(1);
          end
          if (last_c) go_done = 1'b1;
          else        inc     = 1'b1;
        end else if (abort_c) begin
          timeout_n = 1'b1;
          go_done   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (go_done) begin
      state_n = ST_DONE;
      valid_n = 1'b0;
      write_n = 1'b0;
      wdata_n = '0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      pass_n  = !timeout_n && (err_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      mem_valid      <= 1'b0;
      mem_write      <= 1'b0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      wait_cnt       <= '0;
    end else begin
      state          <= state_n;
      mem_valid      <= valid_n;
      mem_write      <= write_n;
      mem_wdata      <= wdata_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      timeout        <= timeout_n;
      err_count      <= err_n;
      first_err_addr <= ferr_n;
      wait_cnt       <= wait_n;
    end
  end

endmodule

// File: tb/tb_mem_seq_master.sv
// Directed bench: write/read-back run, stalls, corruption, timeout, restart, reset and wrap.
module tb_mem_seq_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, r_start;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_valid, mem_ready;
  logic        busy, done, pass, timeout;
  logic [2:0]  err_count;
  logic [31:0] first_err_addr;

  logic [31:0] r_addr, r_wdata, r_rdata, r_ferr;
  logic        r_write, r_valid, r_busy, r_done, r_pass, r_timeout;
  logic [2:0]  r_err;

  int errors = 0;
  int checks = 0;

  int          ready_mode = 0;  // 0 always ready, 1 random stalls, 2 never ready
  logic        corrupt = 1'b0;
  logic [31:0] mem [4];
  int          stall_left = 0;
  logic        hold = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_write;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [31:0] rd_addr [16];
  int          wr_n = 0, rd_n = 0;
  logic [31:0] r_log [16];
  int          r_n = 0;
  logic        r_any_write = 1'b0;
  logic [31:0] exp_a [4];
  logic [31:0] exp_d [4];
  logic [31:0] exp_r [4];

  always #5 clk = ~clk;

  mem_seq_master #(.NUM_WORDS(4), .MODE(1), .TIMEOUT(10)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  mem_seq_master #(.NUM_WORDS(4), .MODE(2), .BASE_ADDR(32'hFFFF_FFF8)) u_rd (
    .clk(clk), .rst(rst), .start(r_start),
    .mem_addr(r_addr), .mem_wdata(r_wdata), .mem_write(r_write),
    .mem_valid(r_valid), .mem_ready(1'b1), .mem_rdata(r_rdata),
    .busy(r_busy), .done(r_done), .pass(r_pass), .timeout(r_timeout),
    .err_count(r_err), .first_err_addr(r_ferr)
  );

  assign mem_rdata = mem[mem_addr[3:2]] ^ ((corrupt && mem_addr == 32'h8) ? 32'h1 : 32'h0);
  assign r_rdata   = 32'hABCD_1234 ^ r_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model, transaction logging and stall scheduling.
  always @(posedge clk) begin
    if (start && !busy) begin
      wr_n = 0;
      rd_n = 0;
      stall_left = $urandom_range(1, 5);
    end
    if (mem_valid && mem_ready) begin
      if (mem_write) begin
        mem[mem_addr[3:2]] = mem_wdata;
        if (wr_n < 16) begin wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_wdata; end
        wr_n++;
      end else begin
        if (rd_n < 16) rd_addr[rd_n] = mem_addr;
        rd_n++;
      end
      stall_left = $urandom_range(0, 5);
    end else if (mem_valid && stall_left > 0) begin
      stall_left--;
    end
    if (ready_mode == 1 && mem_valid && !mem_ready) begin
      hold = 1'b1; h_addr = mem_addr; h_wdata = mem_wdata; h_write = mem_write;
    end else begin
      hold = 1'b0;
    end
    if (r_start && !r_busy) begin r_n = 0; r_any_write = 1'b0; end
    if (r_valid) begin
      if (r_write) r_any_write = 1'b1;
      if (r_n < 16) r_log[r_n] = r_addr;
      r_n++;
    end
  end

  always @(negedge clk) begin
    if (hold) begin
      check("stall_valid", mem_valid, 1);
      check("stall_addr", mem_addr, h_addr);
      check("stall_wdata", mem_wdata, h_wdata);
      check("stall_write", mem_write, h_write);
    end
    mem_ready = (ready_mode == 0) || (ready_mode == 1 && stall_left == 0);
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("done_wait", seen, 1);
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_wr_n"}, wr_n, 4);
    check({tag, "_rd_n"}, rd_n, 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wr_addr"}, wr_addr[i], exp_a[i]);
      check({tag, "_wr_data"}, wr_data[i], exp_d[i]);
      check({tag, "_rd_addr"}, rd_addr[i], exp_a[i]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, mem_valid, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_write"}, mem_write, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_ferr"}, first_err_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_d = '{32'hABCD1234, 32'hABCD1230, 32'hABCD123C, 32'hABCD1238};
    exp_r = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    rst = 1'b1; start = 1'b0; r_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Back-to-back write then read-back, no stalls.
    ready_mode = 0;
    pulse_start();
    check("r1_valid", mem_valid, 1);
    check("r1_write", mem_write, 1);
    check("r1_addr0", mem_addr, 0);
    check("r1_wdata0", mem_wdata, 32'hABCD1234);
    check("r1_busy", busy, 1);
    repeat (7) @(posedge clk);
    #1;
    check("r1_done_early", done, 0);
    check("r1_busy_late", busy, 1);
    @(posedge clk);
    #1;
    check("r1_done", done, 1);
    check("r1_pass", pass, 1);
    check("r1_busy_end", busy, 0);
    check("r1_valid_end", mem_valid, 0);
    check("r1_err", err_count, 0);
    check_logs("r1");

    // Restart from DONE with random stalls.
    ready_mode = 1;
    pulse_start();
    check("r2_done_clr", done, 0);
    check("r2_pass_clr", pass, 0);
    check("r2_valid", mem_valid, 1);
    wait_done(200);
    check("r2_pass", pass, 1);
    check("r2_err", err_count, 0);
    check("r2_timeout", timeout, 0);
    check_logs("r2");

    // Corrupted read data at address 0x8.
    ready_mode = 0;
    corrupt = 1'b1;
    pulse_start();
    wait_done(50);
    check("r3_err", err_count, 1);
    check("r3_ferr", first_err_addr, 32'h8);
    check("r3_pass", pass, 0);
    check("r3_timeout", timeout, 0);
    corrupt = 1'b0;

    // Start while busy is ignored; status from previous run is cleared.
    pulse_start();
    check("r4_err_clr", err_count, 0);
    check("r4_ferr_clr", first_err_addr, 0);
    @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("r4_done_early", done, 0);
    @(posedge clk);
    #1;
    check("r4_done", done, 1);
    check("r4_pass", pass, 1);
    check("r4_wr_n", wr_n, 4);
    check("r4_rd_n", rd_n, 4);

    // Handshake timeout with mem_ready held low.
    ready_mode = 2;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("r5_valid_wait", mem_valid, 1);
    check("r5_timeout_early", timeout, 0);
    @(posedge clk);
    #1;
    check("r5_valid_drop", mem_valid, 0);
    check("r5_timeout", timeout, 1);
    check("r5_done", done, 1);
    check("r5_pass", pass, 0);
    check("r5_busy", busy, 0);

    // Reset in the middle of the write phase.
    ready_mode = 0;
    pulse_start();
    @(posedge clk);
    #1;
    check("r6_addr1", mem_addr, 32'h4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_zero("r6_rst");
    @(negedge clk) rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("r6_no_done", done, 0);
    check("r6_no_valid", mem_valid, 0);

    // Read-only mode with address wrap.
    @(negedge clk) r_start = 1'b1;
    @(posedge clk);
    #1 r_start = 1'b0;
    check("r7_valid", r_valid, 1);
    check("r7_write", r_write, 0);
    check("r7_addr0", r_addr, 32'hFFFFFFF8);
    repeat (3) @(posedge clk);
    #1;
    check("r7_done_early", r_done, 0);
    @(posedge clk);
    #1;
    check("r7_done", r_done, 1);
    check("r7_pass", r_pass, 1);
    check("r7_n", r_n, 4);
    check("r7_no_write", r_any_write, 0);
    for (int i = 0; i < 4; i++) check("r7_addr", r_log[i], exp_r[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_seq_master.md
Name: mem_seq_master

Overview:
- Parametrised successor of the boot-time memory-write stub in the CPU core.
- Issues a programmable burst of single-word writes and optional read-back checks over the core's valid/ready memory interface.
- Reports pass/fail, error count, first failing address and handshake timeout.
- Sits between the CPU core's memory port and the SoC memory/AXI-Lite bridge; used as a boot self-test and bring-up traffic generator.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_WORDS, 16, words per run (>=1)
BASE_ADDR, 0, first address
ADDR_STRIDE, 4, address increment per word
PATTERN, 32'hABCD1234, seed; word i data = PATTERN ^ addr_i, truncated/zero-extended to DATA_W
MODE, 1, 0 = write only, 1 = write then read-back, 2 = read-back only
TIMEOUT, 255, max cycles mem_valid may wait for mem_ready (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle run request
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_write  out  1  1 = write, 0 = read
mem_valid  out  1  request valid
mem_ready  in  1  request accepted; read data valid the same cycle
mem_rdata  in  DATA_W  read data
busy  out  1  run in progress
done  out  1  run finished (sticky until next start)
pass  out  1  run finished with no mismatch and no timeout
timeout  out  1  run aborted on handshake timeout
err_count  out  clog2(NUM_WORDS+1)  read mismatches, saturating
first_err_addr  out  ADDR_W  address of first mismatch

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE; index 0.
  - Reset mid-transaction drops mem_valid at that edge; no completion is reported.
- States: IDLE, WR, RD, DONE.
- IDLE:
  - start=1 moves to WR (MODE 0/1) or RD (MODE 2).
  - mem_valid rises the cycle after start.
  - busy=1 from that same cycle.
- Request handshake:
  - A request is presented with mem_valid=1, mem_addr = BASE_ADDR + i*ADDR_STRIDE (mod 2^ADDR_W), and mem_write/mem_wdata per state.
  - All request outputs are held stable until mem_valid && mem_ready.
  - On acceptance the index increments and the next request is presented the following cycle; mem_valid stays high, so back-to-back beats give 1 word/cycle.
- WR state:
  - After the last accepted write (i = NUM_WORDS-1), MODE 0 goes to DONE.
  - MODE 1 resets the index to 0 and goes to RD; mem_valid remains high with mem_write=0.
- RD state:
  - On acceptance, compare mem_rdata with the expected word.
  - On mismatch, err_count increments, saturating at NUM_WORDS.
  - first_err_addr is captured only when err_count was 0.
  - After the last accepted read, go to DONE.
- DONE:
  - mem_valid=0, busy=0, done=1.
  - pass = (err_count==0 && !timeout), valid while done=1.
- Timeout:
  - A wait counter is cleared on acceptance and on entering a request state.
  - It increments each cycle mem_valid && !mem_ready.
  - When it reaches TIMEOUT, mem_valid drops next cycle, timeout=1, and the block enters DONE with pass=0.
- start handling:
  - start while busy is ignored.
  - start in DONE clears done, pass, timeout, err_count and first_err_addr, then runs again. Status clears on the start cycle; mem_valid rises next cycle.
- Edge cases:
  - NUM_WORDS=1 gives a single beat per phase.
  - mem_ready asserted while mem_valid=0 is ignored.
  - mem_ready and the timeout threshold in the same cycle: acceptance wins.

Decomposition:
- Shared package mem_seq_pkg:
  - State encoding constants (IDLE/WR/RD/DONE).
  - MODE constants (MODE_WR, MODE_WR_RD, MODE_RD).
  - Pattern function word(addr).
- One natural sub-module, mem_seq_addr_gen: index counter, address computation and the last-beat flag.
- Handshake/timeout and checking stay in the top level.

Test Plan:
- MODE 1, NUM_WORDS=4, memory model with mem_ready always 1:
  - Writes go to addresses 0, 4, 8, 0xC with data 0xABCD1234, 0xABCD1230, 0xABCD123C, 0xABCD1238.
  - Reads follow back-to-back.
  - done and pass assert 9 cycles after start.
- Random mem_ready stalls of 0-5 cycles on the same run: mem_addr, mem_wdata and mem_write stay stable during each stall; results match the no-stall run.
- Memory model corrupts the word at 0x8 on read: err_count=1, first_err_addr=0x8, pass=0.
- mem_ready held 0 with TIMEOUT=10: mem_valid drops after 10 waiting cycles; timeout=1, done=1, pass=0.
- start pulsed while busy has no effect. start in DONE clears status and repeats the run. rst asserted mid-write drops mem_valid at that edge, and all outputs read 0.
- MODE 2 with BASE_ADDR=0xFFFFFFF8, NUM_WORDS=4: addresses wrap to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; no write is ever issued.
